// File: rtl/ftrace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ftrace_pkg
//  Description : Shared opcode/register constants, trace event payload type
//                and jal/jalr call/return classifier for the ftrace feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ftrace_pkg;

  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd1;
  localparam logic [4:0] REG_T0   = 5'd5;

  // Payload carried through the event FIFO.
  typedef struct packed {
    logic        is_jal;
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic [31:0] inst;
    logic [4:0]  rd;
  } ftrace_evt_t;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_CALL = 2'd1,
    EVT_RET  = 2'd2
  } evt_kind_e;

  // Calls link through ra or t0; a return is exactly "jalr x0, 0(ra)".
  function automatic evt_kind_e classify(input logic [31:0] inst);
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [11:0] imm;
    logic        link_rd;
    opcode  = inst[6:0];
    rd      = inst[11:7];
    rs1     = inst[19:15];
    imm     = inst[31:20];
    link_rd = (rd == REG_RA) || (rd == REG_T0);
    if (((opcode == OP_JAL) || (opcode == OP_JALR)) && link_rd)
      return EVT_CALL;
    if ((opcode == OP_JALR) && (rd == REG_ZERO) && (rs1 == REG_RA) && (imm == 12'd0))
      return EVT_RET;
    return EVT_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ftrace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ftrace_fifo
//  Description : Generic synchronous FIFO, DEPTH entries (power of two, >= 2),
//                payload type ITEM_T. A push while full is accepted only when
//                a pop happens in the same cycle. The head reads as zero when
//                the FIFO is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module ftrace_fifo #(
  parameter int  DEPTH  = 4,
  parameter type ITEM_T = logic [7:0]
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  push,
  input  ITEM_T push_data,
  input  logic  pop,
  output ITEM_T head,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  ITEM_T       mem [DEPTH];
  logic        do_pop;
  logic        do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer registers; reset flushes every queued entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: stale entries are masked while empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

  // Head entry, forced to zero when nothing is queued.
  always_comb begin
    head = '0;
    if (!empty) head = mem[rptr[AW-1:0]];
  end

endmodule
`default_nettype wire

// File: rtl/ftrace_event_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ftrace_event_gen
//  Description : Decodes jal/jalr on the retire stream into call/return
//                events, queues them and presents one per cycle to the
//                function-trace stage. Overflow drops and counts events
//                rather than stalling the core.
//                Build option FTRACE_DEPTH_EN adds the call_depth counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module ftrace_event_gen
  import ftrace_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             commit_valid,
  input  logic [31:0]      commit_pc,
  input  logic [31:0]      commit_nextpc,
  input  logic [31:0]      commit_inst,
  input  logic             out_ready,
  output logic             func_flag,
  output logic             is_jal,
  output logic [31:0]      pc,
  output logic [31:0]      nextpc,
  output logic [31:0]      rd,
  output logic [31:0]      inst,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
`ifdef FTRACE_DEPTH_EN
  ,
  output logic [7:0]       call_depth
`endif
);

  evt_kind_e   kind;
  logic        evt_valid;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        drop;
  ftrace_evt_t new_evt;
  ftrace_evt_t head_evt;

  assign kind      = commit_valid ? classify(commit_inst) : EVT_NONE;
  assign evt_valid = (kind != EVT_NONE);

  assign new_evt = '{is_jal: (kind == EVT_CALL),
                     pc:     commit_pc,
                     nextpc: commit_nextpc,
                     inst:   commit_inst,
                     rd:     commit_inst[11:7]};

  assign pop  = func_flag & out_ready;
  // A pop in the same cycle frees the slot, so only full-without-pop drops.
  assign drop = evt_valid & fifo_full & ~pop;

  ftrace_fifo #(
    .DEPTH  (DEPTH),
    .ITEM_T (ftrace_evt_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (evt_valid),
    .push_data (new_evt),
    .pop       (pop),
    .head      (head_evt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign func_flag = ~fifo_empty;
  assign is_jal    = head_evt.is_jal;
  assign pc        = head_evt.pc;
  assign nextpc    = head_evt.nextpc;
  assign inst      = head_evt.inst;
  assign rd        = {27'd0, head_evt.rd};

  // Saturating drop counter and sticky overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
    end
  end

`ifdef FTRACE_DEPTH_EN
  // Nesting depth follows enqueue-time decode, including dropped events.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      call_depth <= 8'd0;
    end else if ((kind == EVT_CALL) && (call_depth != 8'hFF)) begin
      call_depth <= call_depth + 8'd1;
    end else if ((kind == EVT_RET) && (call_depth != 8'd0)) begin
      call_depth <= call_depth - 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ftrace_event_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ftrace_event_gen
//  Description : Self-checking bench for ftrace_event_gen. A queue-based
//                reference model predicts every output; directed steps cover
//                the main scenarios followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ftrace_event_gen;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset;
  logic             commit_valid;
  logic [31:0]      commit_pc;
  logic [31:0]      commit_nextpc;
  logic [31:0]      commit_inst;
  logic             out_ready;
  logic             func_flag;
  logic             is_jal;
  logic [31:0]      pc;
  logic [31:0]      nextpc;
  logic [31:0]      rd;
  logic [31:0]      inst;
  logic [CNT_W-1:0] drop_cnt;
  logic             overflow;
`ifdef FTRACE_DEPTH_EN
  logic [7:0]       call_depth;
`endif

  ftrace_event_gen #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .commit_valid  (commit_valid),
    .commit_pc     (commit_pc),
    .commit_nextpc (commit_nextpc),
    .commit_inst   (commit_inst),
    .out_ready     (out_ready),
    .func_flag     (func_flag),
    .is_jal        (is_jal),
    .pc            (pc),
    .nextpc        (nextpc),
    .rd            (rd),
    .inst          (inst),
    .drop_cnt      (drop_cnt),
    .overflow      (overflow)
`ifdef FTRACE_DEPTH_EN
    ,
    .call_depth    (call_depth)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state: expected queue contents and counters.
  typedef struct packed {
    bit        is_jal;
    bit [31:0] pc;
    bit [31:0] nextpc;
    bit [31:0] inst;
    bit [31:0] rd;
  } exp_evt_t;

  exp_evt_t q[$];
  int       drops;
  int       depth;
  int       vectors;
  int       miscompares;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 = no event, 1 = call, 2 = return, from the instruction-field rules.
  function automatic int model_kind(input bit [31:0] w);
    int op  = int'(w & 32'h7F);
    int rdf = int'((w >> 7) & 32'h1F);
    int rs1 = int'((w >> 15) & 32'h1F);
    int imm = int'(w >> 20);
    if ((op == 'h6F || op == 'h67) && (rdf == 1 || rdf == 5)) return 1;
    if (op == 'h67 && rdf == 0 && rs1 == 1 && imm == 0) return 2;
    return 0;
  endfunction

  task automatic model_step(input bit v, input bit [31:0] p, input bit [31:0] np,
                            input bit [31:0] w, input bit rdy);
    int       k;
    bit       was_full;
    bit       popped;
    exp_evt_t e;
    was_full = (q.size() == DEPTH);
    popped   = (q.size() > 0) && rdy;
    if (popped) void'(q.pop_front());
    k = v ? model_kind(w) : 0;
    if (k != 0) begin
      e.is_jal = (k == 1);
      e.pc     = p;
      e.nextpc = np;
      e.inst   = w;
      e.rd     = (w >> 7) & 32'h1F;
      if (!was_full || popped) q.push_back(e);
      else drops++;
      if (k == 1) depth = (depth >= 255) ? 255 : depth + 1;
      else        depth = (depth <= 0)   ? 0   : depth - 1;
    end
  endtask

  task automatic check_outputs(input string ph);
    exp_evt_t h;
    bit       ne;
    ne = (q.size() != 0);
    h  = ne ? q[0] : '0;
    check({ph, ".func_flag"}, func_flag, ne);
    check({ph, ".is_jal"},    is_jal,    h.is_jal);
    check({ph, ".pc"},        pc,        h.pc);
    check({ph, ".nextpc"},    nextpc,    h.nextpc);
    check({ph, ".inst"},      inst,      h.inst);
    check({ph, ".rd"},        rd,        h.rd);
    check({ph, ".drop_cnt"},  drop_cnt,  (drops > CNT_MAX) ? CNT_MAX : drops);
    check({ph, ".overflow"},  overflow,  drops > 0);
`ifdef FTRACE_DEPTH_EN
    check({ph, ".call_depth"}, call_depth, depth);
`endif
  endtask

  // Drive one commit at the falling edge, advance the model at the rising
  // edge, and compare at the next falling edge.
  task automatic cycle(input string ph, input bit v, input bit [31:0] p,
                       input bit [31:0] np, input bit [31:0] w, input bit rdy);
    commit_valid  = v;
    commit_pc     = p;
    commit_nextpc = np;
    commit_inst   = w;
    out_ready     = rdy;
    @(posedge clock);
    model_step(v, p, np, w, rdy);
    @(negedge clock);
    check_outputs(ph);
  endtask

  function automatic bit [31:0] mk_jal(input bit [4:0] r, input bit [19:0] imm);
    return {imm, r, 7'h6F};
  endfunction

  function automatic bit [31:0] mk_jalr(input bit [4:0] r, input bit [4:0] s, input bit [11:0] imm);
    return {imm, s, 3'b000, r, 7'h67};
  endfunction

  task automatic model_clear();
    q.delete();
    drops = 0;
    depth = 0;
  endtask

  initial begin
    bit [31:0] w;
    bit [4:0]  s;
    bit [11:0] im;
    int        sel;
    int        rdy_pct;
    vectors      = 0;
    miscompares  = 0;
    model_clear();
    commit_valid  = 1'b0;
    commit_pc     = '0;
    commit_nextpc = '0;
    commit_inst   = '0;
    out_ready     = 1'b1;

    // Reset state
    reset = 1'b0;
    #1;
    check_outputs("reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    cycle("idle", 0, 0, 0, 0, 1);

    // Call: jal ra,+0x10
    cycle("call", 1, 32'h8000_0000, 32'h8000_0010, 32'h010000EF, 1);
    check("call.flag_const",   func_flag, 1);
    check("call.is_jal_const", is_jal,    1);
    check("call.rd_const",     rd,        1);
    check("call.nextpc_const", nextpc,    32'h8000_0010);

    // Return
    cycle("ret", 1, 32'h8000_0020, 32'h8000_0004, 32'h00008067, 1);
    check("ret.is_jal_const", is_jal, 0);
    check("ret.rd_const",     rd,     0);

    // Non-events
    cycle("jal_x0", 1, 32'h8000_0030, 32'h8000_0040, 32'h0000006F, 1);
    cycle("addi",   1, 32'h8000_0034, 32'h8000_0038, 32'h00000013, 1);
    check("noevt.flag_const", func_flag, 0);
    cycle("jalr_x0", 1, 32'h8000_0038, 32'h8000_0100, mk_jalr(0, 6, 12'h000), 1);

    // Back-pressure: six calls into a four-entry FIFO
    for (int i = 0; i < 6; i++)
      cycle("fill", 1, 32'h8000_1000 + 32'(i * 4), 32'h8000_2000 + 32'(i * 16),
            (i % 2 == 0) ? 32'h010000EF : mk_jal(5, 20'h00123), 0);
    check("fill.drop_const",     drop_cnt, 2);
    check("fill.overflow_const", overflow, 1);

    // Full with simultaneous pop and push
    cycle("full_pop_push", 1, 32'h8000_3000, 32'h8000_3100, mk_jalr(1, 7, 12'h040), 1);
    check("full_pop_push.drop_const", drop_cnt, 2);

    // Drain in order
    for (int i = 0; i < 5; i++) cycle("drain", 0, 0, 0, 0, 1);

    // Asynchronous reset with three queued events
    for (int i = 0; i < 3; i++)
      cycle("preq", 1, 32'h8000_4000 + 32'(i * 4), 32'h8000_5000, 32'h010000EF, 0);
    check("preq.flag_const", func_flag, 1);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check("async_rst.func_flag", func_flag, 0);
    @(negedge clock);
    check_outputs("in_rst");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle("post_rst", 0, 0, 0, 0, 1);

    // Randomized traffic with varying back-pressure
    for (int i = 0; i < 600; i++) begin
      rdy_pct = (i < 200) ? 90 : ((i < 400) ? 40 : 70);
      sel = $urandom_range(0, 5);
      s   = 5'($urandom_range(0, 31));
      im  = 12'($urandom);
      case (sel)
        0:       w = mk_jal(($urandom_range(0, 1) != 0) ? 5'd1 : 5'd5, 20'($urandom));
        1:       w = mk_jalr(($urandom_range(0, 1) != 0) ? 5'd1 : 5'd5, s, im);
        2:       w = 32'h00008067;
        3:       w = mk_jal(5'($urandom_range(0, 31)), 20'($urandom));
        4:       w = mk_jalr(0, s, ($urandom_range(0, 1) != 0) ? 12'd0 : im);
        default: w = $urandom;
      endcase
      cycle("rand", $urandom_range(0, 9) != 0, $urandom, $urandom, w,
            $urandom_range(0, 99) < rdy_pct);
    end

    // Depth saturation and floor
    for (int i = 0; i < 262; i++)
      cycle("sat", 1, 32'h9000_0000, 32'h9000_0100, 32'h010000EF, 1);
    for (int i = 0; i < 262; i++)
      cycle("floor", 1, 32'h9000_0200, 32'h9000_0004, 32'h00008067, 1);
    cycle("final", 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
